text_console_ctrl: RTL and testbench

Sequencer that turns a byte stream into writes to the 40×30 text VRAM read by the character-cell video path. It owns a cursor and decodes control characters. It performs hardware scrolling by rotating a top-row offset, which the scan-out reader adds to its row index, and by clearing the recycled row. It sits between a byte source (UART RX, CPU port) and the VRAM write port.

---
 rtl/console_pkg.sv | 32 +++
 rtl/console_addr.sv | 18 +
 rtl/text_console_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared constants, control codes, state encoding and row-wrap helper for
// the text console sequencer (40x30 character VRAM).
package console_pkg;

    localparam int unsigned COLS  = 40;
    localparam int unsigned ROWS  = 30;
    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned AW    = 11;   // VRAM cell address width
    localparam int unsigned XW    = 6;    // cursor column width
    localparam int unsigned YW    = 5;    // row index width

    localparam logic [7:0] BLANK_CHR = 8'h20;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_FF    = 8'h0C;

    typedef enum logic [1:0] {
        IDLE,
        PUT,
        CLR_LINE,
        CLR_ALL
    } state_e;

    // Reduce a sum of two row indices (each < ROWS) modulo ROWS without a divider.
    function automatic logic [YW-1:0] wrap_row(input logic [YW:0] s);
        logic [YW:0] r;
        r = (s >= (YW+1)'(ROWS)) ? (s - (YW+1)'(ROWS)) : s;
        return r[YW-1:0];
    endfunction

endpackage

// File: rtl/console_addr.sv
// Combinational VRAM address: prow = (row_a + row_b) mod ROWS,
// addr = prow*COLS + col, with prow*40 formed as prow*32 + prow*8.
// Ports: row_a_i/row_b_i row operands, col_i column, prow_o physical row,
//        addr_o cell address.
module console_addr
    import console_pkg::*;
(
    input  logic [YW-1:0] row_a_i,
    input  logic [YW-1:0] row_b_i,
    input  logic [XW-1:0] col_i,
    output logic [YW-1:0] prow_o,
    output logic [AW-1:0] addr_o
);

    assign prow_o = wrap_row({1'b0, row_a_i} + {1'b0, row_b_i});
    assign addr_o = AW'({prow_o, 5'b0}) + AW'({prow_o, 3'b0}) + AW'(col_i);

endmodule

// File: rtl/text_console_ctrl.sv
// Byte-stream to VRAM write sequencer with cursor, control-code decode and
// hardware scrolling by rotating top_row and clearing the recycled row.
// Ports: clk, rst_n (async active-low); in_valid_i/in_data_i/in_ready_o byte
//        input; de_i display enable; vram_we_o/vram_ad_o/vram_wd_o VRAM write
//        port; top_row_o scroll offset; cur_x_o/cur_y_o cursor; busy_o clear
//        in progress.
// Build option: BLANK_WRITE_EN restricts VRAM writes to de_i=0 cycles.
module text_console_ctrl
    import console_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    input  logic          de_i,
    output logic          vram_we_o,
    output logic [AW-1:0] vram_ad_o,
    output logic [7:0]    vram_wd_o,
    output logic [YW-1:0] top_row_o,
    output logic [XW-1:0] cur_x_o,
    output logic [YW-1:0] cur_y_o,
    output logic          busy_o
);

    state_e        state_q;
    logic [XW-1:0] cur_x_q;
    logic [YW-1:0] cur_y_q;
    logic [YW-1:0] top_row_q;
    logic [YW-1:0] line_q;     // physical row being cleared by CLR_LINE
    logic [AW-1:0] cnt_q;
    logic          we_q;
    logic [AW-1:0] ad_q;
    logic [7:0]    wd_q;

    logic          wr_en;
`ifdef BLANK_WRITE_EN
    assign wr_en     = ~de_i;
    assign vram_we_o = we_q & wr_en;
`else
    logic unused_de;
    assign unused_de = de_i;
    assign wr_en     = 1'b1;
    assign vram_we_o = we_q;
`endif

    // A pending write that could not issue this cycle freezes the sequencer.
    logic stall;
    assign stall = we_q & ~wr_en;

    logic accept;
    assign accept = in_valid_i && (state_q == IDLE);

    logic last_row;
    assign last_row = (cur_y_q == YW'(ROWS - 1));

    logic [YW-1:0] top_inc;
    assign top_inc = wrap_row({1'b0, top_row_q} + (YW+1)'(1));

    // Address source: clear row during CLR_LINE, start of top row when a
    // scroll may begin, otherwise the cursor cell.
    logic          sel_clr;
    logic          sel_top;
    logic [YW-1:0] a_row_a;
    logic [YW-1:0] a_row_b;
    logic [XW-1:0] a_col;
    logic [YW-1:0] prow_unused;
    logic [AW-1:0] addr;

    assign sel_clr = (state_q == CLR_LINE);
    assign sel_top = (state_q == PUT) || ((state_q == IDLE) && (in_data_i == CHR_LF));
    assign a_row_a = sel_clr ? line_q : top_row_q;
    assign a_row_b = (sel_clr || sel_top) ? '0 : cur_y_q;
    assign a_col   = sel_clr ? cnt_q[XW-1:0] : (sel_top ? '0 : cur_x_q);

    console_addr u_addr (
        .row_a_i (a_row_a),
        .row_b_i (a_row_b),
        .col_i   (a_col),
        .prow_o  (prow_unused),
        .addr_o  (addr)
    );

    // Sequencer FSM; entering a clear issues its first write on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLR_ALL;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            top_row_q <= '0;
            line_q    <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            ad_q      <= '0;
            wd_q      <= BLANK_CHR;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (in_data_i >= 8'h20) begin
                            we_q    <= 1'b1;
                            ad_q    <= addr;
                            wd_q    <= in_data_i;
                            state_q <= PUT;
                        end else begin
                            case (in_data_i)
                                CHR_CR: cur_x_q <= '0;
                                CHR_LF: begin
                                    cur_x_q <= '0;
                                    if (!last_row) begin
                                        cur_y_q <= cur_y_q + YW'(1);
                                    end else begin
                                        top_row_q <= top_inc;
                                        line_q    <= top_row_q;
                                        we_q      <= 1'b1;
                                        ad_q      <= addr;
                                        wd_q      <= BLANK_CHR;
                                        cnt_q     <= AW'(1);
                                        state_q   <= CLR_LINE;
                                    end
                                end
                                CHR_BS: begin
                                    if (cur_x_q != '0) cur_x_q <= cur_x_q - XW'(1);
                                end
                                CHR_FF: begin
                                    we_q    <= 1'b1;
                                    ad_q    <= '0;
                                    wd_q    <= BLANK_CHR;
                                    cnt_q   <= AW'(1);
                                    state_q <= CLR_ALL;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                PUT: begin
                    if (wr_en) begin
                        we_q <= 1'b0;
                        if (cur_x_q == XW'(COLS - 1)) begin
                            cur_x_q <= '0;
                            if (!last_row) begin
                                cur_y_q <= cur_y_q + YW'(1);
                                state_q <= IDLE;
                            end else begin
                                top_row_q <= top_inc;
                                line_q    <= top_row_q;
                                we_q      <= 1'b1;
                                ad_q      <= addr;
                                wd_q      <= BLANK_CHR;
                                cnt_q     <= AW'(1);
                                state_q   <= CLR_LINE;
                            end
                        end else begin
                            cur_x_q <= cur_x_q + XW'(1);
                            state_q <= IDLE;
                        end
                    end
                end
                CLR_LINE: begin
                    if (!stall) begin
                        if (cnt_q < AW'(COLS)) begin
                            we_q  <= 1'b1;
                            ad_q  <= addr;
                            wd_q  <= BLANK_CHR;
                            cnt_q <= cnt_q + AW'(1);
                        end else begin
                            we_q    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                CLR_ALL: begin
                    if (!stall) begin
                        if (cnt_q < AW'(CELLS)) begin
                            we_q  <= 1'b1;
                            ad_q  <= cnt_q;
                            wd_q  <= BLANK_CHR;
                            cnt_q <= cnt_q + AW'(1);
                        end else begin
                            we_q      <= 1'b0;
                            cur_x_q   <= '0;
                            cur_y_q   <= '0;
                            top_row_q <= '0;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o = (state_q == IDLE);
    assign busy_o     = (state_q == CLR_LINE) || (state_q == CLR_ALL);
    assign vram_ad_o  = ad_q;
    assign vram_wd_o  = wd_q;
    assign top_row_o  = top_row_q;
    assign cur_x_o    = cur_x_q;
    assign cur_y_o    = cur_y_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed scoreboard bench for text_console_ctrl.
module tb_text_console_ctrl;

    localparam int COLS_T = 40;
    localparam int ROWS_T = 30;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;
    logic        de_i;
    logic        vram_we_o;
    logic [10:0] vram_ad_o;
    logic [7:0]  vram_wd_o;
    logic [4:0]  top_row_o;
    logic [5:0]  cur_x_o;
    logic [4:0]  cur_y_o;
    logic        busy_o;

    text_console_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .de_i       (de_i),
        .vram_we_o  (vram_we_o),
        .vram_ad_o  (vram_ad_o),
        .vram_wd_o  (vram_wd_o),
        .top_row_o  (top_row_o),
        .cur_x_o    (cur_x_o),
        .cur_y_o    (cur_y_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] ad;
        logic [7:0]  wd;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  wr_cnt = 0;
    int  mx = 0, my = 0, mtop = 0;

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        wr_t e;
        #3;
        if (rst_n === 1'b1 && vram_we_o === 1'b1) begin
            wr_cnt++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL wr_unexpected got ad=%0d wd=%h, required no write", vram_ad_o, vram_wd_o);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                assert ({vram_ad_o, vram_wd_o} === {e.ad, e.wd}) else begin
                    bad++;
                    $error("FAIL wr_data got ad=%0d wd=%h, required ad=%0d wd=%h",
                           vram_ad_o, vram_wd_o, e.ad, e.wd);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_clear(input int first, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{ad: 11'(first + i), wd: 8'h20});
    endtask

    task automatic model_newline();
        mx = 0;
        if (my < ROWS_T - 1) my++;
        else begin
            push_clear(mtop * COLS_T, COLS_T);
            mtop = (mtop + 1) % ROWS_T;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20) begin
            exp_q.push_back('{ad: 11'(((mtop + my) % ROWS_T) * COLS_T + mx), wd: b});
            mx++;
            if (mx == COLS_T) model_newline();
        end else if (b == 8'h0D) mx = 0;
        else if (b == 8'h0A) model_newline();
        else if (b == 8'h08) begin
            if (mx > 0) mx--;
        end else if (b == 8'h0C) begin
            push_clear(0, COLS_T * ROWS_T);
            mx = 0; my = 0; mtop = 0;
        end
    endtask

    task automatic wait_ready(input int max);
        int n = 0;
        while (in_ready_o !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(in_ready_o), 1);
    endtask

    // Offer one byte when ready; afterwards scramble in_data to prove one-shot sampling.
    task automatic send(input logic [7:0] b);
        int n = 0;
        while (in_ready_o !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        model_byte(b);
        in_valid_i = 1'b1;
        in_data_i  = b;
        tick();
        in_valid_i = 1'b0;
        in_data_i  = 8'($urandom);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_x"},   32'(cur_x_o),   mx);
        chk({tag, "_y"},   32'(cur_y_o),   my);
        chk({tag, "_top"}, 32'(top_row_o), mtop);
    endtask

    initial begin
        int w0;
        rst_n = 1'b0; in_valid_i = 1'b0; in_data_i = 8'h00; de_i = 1'b0;
        tick(); tick();
        chk("rst_we",    32'(vram_we_o),  0);
        chk("rst_ad",    32'(vram_ad_o),  0);
        chk("rst_wd",    32'(vram_wd_o),  32'h20);
        chk("rst_x",     32'(cur_x_o),    0);
        chk("rst_y",     32'(cur_y_o),    0);
        chk("rst_top",   32'(top_row_o),  0);
        chk("rst_ready", 32'(in_ready_o), 0);
        chk("rst_busy",  32'(busy_o),     1);

        // Power-up clear
        push_clear(0, COLS_T * ROWS_T);
        rst_n = 1'b1;
        wait_ready(1300);
        chk("init_writes", 32'(wr_cnt),        1200);
        chk("init_busy",   32'(busy_o),        0);
        chk("init_q",      32'(exp_q.size()),  0);
        chk_model("init");

        // Single printable: write strobe with ready low, then ready back
        send(8'h41);
        chk("put_we",    32'(vram_we_o),  1);
        chk("put_ready", 32'(in_ready_o), 0);
        tick();
        chk("put_ready2", 32'(in_ready_o), 1);
        chk("put_x",      32'(cur_x_o),    1);

        // Full row from home wraps to next row
        send(8'h0D);
        chk("cr_ready", 32'(in_ready_o), 1);
        chk("cr_x",     32'(cur_x_o),    0);
        for (int i = 0; i < COLS_T; i++) send(8'(8'h30 + (i % 10)));
        wait_ready(10);
        chk("row_x", 32'(cur_x_o), 0);
        chk("row_y", 32'(cur_y_o), 1);

        // CR, LF, BS at x=0: no writes, one byte per cycle
        w0 = wr_cnt;
        send(8'h0D); send(8'h0A); send(8'h08);
        chk("ctl_ready",  32'(in_ready_o), 1);
        chk("ctl_writes", 32'(wr_cnt),     w0);
        chk("ctl_x",      32'(cur_x_o),    0);
        chk("ctl_y",      32'(cur_y_o),    2);

        // Dropped control code and BS with x>0
        send(8'h78); send(8'h79); send(8'h01); send(8'h08);
        wait_ready(10);
        chk("bs_x", 32'(cur_x_o), 1);
        chk_model("bs");
        send(8'h0D);

        // Reach (5,29) then scroll once
        for (int i = 0; i < 27; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61);
        wait_ready(10);
        chk("pre_x",   32'(cur_x_o),   5);
        chk("pre_y",   32'(cur_y_o),   29);
        chk("pre_top", 32'(top_row_o), 0);
        send(8'h0A);
        chk("scr_busy", 32'(busy_o),    1);
        chk("scr_top",  32'(top_row_o), 1);
        wait_ready(60);
        chk("scr_x", 32'(cur_x_o), 0);
        chk("scr_y", 32'(cur_y_o), 29);
        send(8'h42);
        wait_ready(10);
        chk("b_q", 32'(exp_q.size()), 0);

        // Scroll up to top_row=29, then wrap to 0 clearing row 29
        send(8'h0D);
        for (int i = 0; i < 28; i++) send(8'h0A);
        wait_ready(60);
        chk("t29_top", 32'(top_row_o), 29);
        send(8'h0A);
        wait_ready(60);
        chk("wrap_top", 32'(top_row_o), 0);
        chk("wrap_q",   32'(exp_q.size()), 0);
        chk_model("wrap");

        // Printable in last cell of last row: PUT then scroll
        for (int i = 0; i < COLS_T; i++) send(8'h5A);
        wait_ready(60);
        chk("last_top", 32'(top_row_o), 1);
        chk("last_q",   32'(exp_q.size()), 0);
        chk_model("last");

        // Form feed clears the whole screen
        w0 = wr_cnt;
        send(8'h0C);
        wait_ready(1300);
        chk("ff_writes", 32'(wr_cnt - w0), 1200);
        chk("ff_top",    32'(top_row_o),   0);
        chk("ff_x",      32'(cur_x_o),     0);
        chk("ff_y",      32'(cur_y_o),     0);

        // Reset in the middle of a clear restarts from address 0
        send(8'h0C);
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        chk("mrst_we",   32'(vram_we_o), 0);
        chk("mrst_busy", 32'(busy_o),    1);
        mx = 0; my = 0; mtop = 0;
        push_clear(0, COLS_T * ROWS_T);
        rst_n = 1'b1;
        wait_ready(1300);
        chk("mrst_q", 32'(exp_q.size()), 0);

`ifdef BLANK_WRITE_EN
        // Writes held off during active video
        de_i = 1'b1;
        send(8'h43);
        for (int i = 0; i < 4; i++) begin
            chk("de_we",    32'(vram_we_o),  0);
            chk("de_ready", 32'(in_ready_o), 0);
            tick();
        end
        de_i = 1'b0;
        #1;
        chk("de_release_we", 32'(vram_we_o), 1);
        chk("de_release_ad", 32'(vram_ad_o), 0);
        tick();
        wait_ready(10);
        chk("de_x", 32'(cur_x_o), 1);
`endif

        tick(); tick();
        chk("end_q", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
